array_ram: RTL and testbench



---
 rtl/array_ram_pkg.sv | 19 +
 rtl/array_ram_core.sv | 55 +++++
 rtl/array_ram.sv | 135 +++++++++++++
 tb/tb_array_ram.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/array_ram_pkg.sv
// array_ram_pkg
// Shared definitions for the array_ram slice: default channel widths and
// the controller state encoding.
package array_ram_pkg;

   localparam int ADDR_N_DEF = 8;
   localparam int INT_N_DEF  = 8;

   // state    | meaning
   // ST_INIT  | clearing memory word by word, channel closed
   // ST_IDLE  | no response outstanding, ready for a request
   // ST_RESP  | one response held on the response channel
   typedef enum logic [1:0] {
      ST_INIT = 2'd0,
      ST_IDLE = 2'd1,
      ST_RESP = 2'd2
   } state_e;

endpackage

// File: rtl/array_ram_core.sv
// array_ram_core
// Single-port synchronous RAM, 2^addrN x intN, with a registered
// read-before-write data output.
// Ports:
//   clk    - clock, rising edge
//   reset  - synchronous active-high, clears the output register only
//   wr_en  - write di to mem[addr] on this edge
//   rd_en  - capture the pre-write contents of mem[addr] into dout
//   addr   - word address
//   di     - write data
//   dout   - registered read data, held when rd_en is low
module array_ram_core
   import array_ram_pkg::*;
#(
   parameter int addrN = ADDR_N_DEF,
   parameter int intN  = INT_N_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic             rd_en,
   input  logic [addrN-1:0] addr,
   input  logic [intN-1:0]  di,
   output logic [intN-1:0]  dout
);

   logic [intN-1:0] mem [2**addrN];
   logic [intN-1:0] dout_q, dout_d;

   // Storage has no reset; the controller clears it by explicit writes.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[addr] <= di;
      end
   end

   // Read and write share the edge, so the read sees the old contents.
   always_comb begin
      dout_d = dout_q;
      if (rd_en) begin
         dout_d = mem[addr];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         dout_q <= '0;
      end else begin
         dout_q <= dout_d;
      end
   end

   assign dout = dout_q;

endmodule

// File: rtl/array_ram.sv
// array_ram
// Word-addressed memory serving one Array channel. Clears itself after
// reset, then handles one read or write per cycle with a valid/ready
// request channel and an in-order valid/ready response channel. Writes
// return the word's previous contents (fetch-and-replace).
// Ports:
//   clk, reset      - clock and synchronous active-high reset
//   arr_valid/ready - request handshake
//   arr_we          - 1 = write, 0 = read
//   arr_addr        - word address
//   arr_di          - write data
//   arr_resp_valid  - response handshake (valid out)
//   arr_resp_ready  - response handshake (ready in)
//   arr_do          - response data
//
// state    | meaning
// ST_INIT  | clear counter writes zero to word cnt, arr_ready low
// ST_IDLE  | arr_ready high, waiting for a request
// ST_RESP  | response valid; arr_ready follows arr_resp_ready
module array_ram
   import array_ram_pkg::*;
#(
   parameter int addrN = ADDR_N_DEF,
   parameter int intN  = INT_N_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             arr_valid,
   output logic             arr_ready,
   input  logic             arr_we,
   input  logic [addrN-1:0] arr_addr,
   input  logic [intN-1:0]  arr_di,
   output logic             arr_resp_valid,
   input  logic             arr_resp_ready,
   output logic [intN-1:0]  arr_do
);

   state_e           state_q, state_d;
   logic [addrN-1:0] cnt_q, cnt_d;
   logic             resp_valid_q, resp_valid_d;

   logic             accept;
   logic             consume;
   logic             mem_we;
   logic [addrN-1:0] mem_addr;
   logic [intN-1:0]  mem_di;

   // Ready depends only on state and the consumer, never on arr_valid.
   always_comb begin
      arr_ready = 1'b0;
      unique case (state_q)
         ST_IDLE: arr_ready = 1'b1;
         ST_RESP: arr_ready = arr_resp_ready;
         default: arr_ready = 1'b0;
      endcase
   end

   assign accept  = arr_valid & arr_ready & ~reset;
   assign consume = resp_valid_q & arr_resp_ready;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      resp_valid_d = resp_valid_q;
      if (reset) begin
         state_d      = ST_INIT;
         cnt_d        = '0;
         resp_valid_d = 1'b0;
      end else begin
         unique case (state_q)
            ST_INIT: begin
               // Counter parks on the last word instead of wrapping.
               if (cnt_q == {addrN{1'b1}}) begin
                  state_d = ST_IDLE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            ST_IDLE: begin
               if (accept) begin
                  state_d      = ST_RESP;
                  resp_valid_d = 1'b1;
               end
            end
            ST_RESP: begin
               if (consume && !accept) begin
                  state_d      = ST_IDLE;
                  resp_valid_d = 1'b0;
               end
            end
            default: begin
               state_d      = ST_INIT;
               cnt_d        = '0;
               resp_valid_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
   end

   // The clear sequence borrows the single RAM port while the channel is closed.
   always_comb begin
      mem_we   = 1'b0;
      mem_addr = arr_addr;
      mem_di   = arr_di;
      if (state_q == ST_INIT) begin
         mem_we   = 1'b1;
         mem_addr = cnt_q;
         mem_di   = '0;
      end else if (accept && arr_we) begin
         mem_we = 1'b1;
      end
   end

   array_ram_core #(
      .addrN (addrN),
      .intN  (intN)
   ) u_core (
      .clk   (clk),
      .reset (reset),
      .wr_en (mem_we),
      .rd_en (accept),
      .addr  (mem_addr),
      .di    (mem_di),
      .dout  (arr_do)
   );

   assign arr_resp_valid = resp_valid_q;

endmodule

// File: tb/tb_array_ram.sv
module tb_array_ram;

   logic       clk = 1'b0;
   logic       reset;
   logic       arr_valid;
   logic       arr_ready;
   logic       arr_we;
   logic [7:0] arr_addr;
   logic [7:0] arr_di;
   logic       arr_resp_valid;
   logic       arr_resp_ready;
   logic [7:0] arr_do;

   always #5 clk = ~clk;

   array_ram #(.addrN(8), .intN(8)) dut (
      .clk            (clk),
      .reset          (reset),
      .arr_valid      (arr_valid),
      .arr_ready      (arr_ready),
      .arr_we         (arr_we),
      .arr_addr       (arr_addr),
      .arr_di         (arr_di),
      .arr_resp_valid (arr_resp_valid),
      .arr_resp_ready (arr_resp_ready),
      .arr_do         (arr_do)
   );

   // Reference: contents as a plain array, outstanding responses as a queue,
   // and the number of clear cycles still to run after reset.
   logic [7:0] mem_m [256];
   logic [7:0] exp_q [$];
   int         init_left = 256;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // Called at a falling edge: drive, check ready, advance the model across
   // the rising edge, then check the response channel at the next falling edge.
   task automatic step(input bit rst, input bit v, input bit we,
                       input logic [7:0] a, input logic [7:0] d, input bit rr);
      bit ready_m;
      bit acc;
      reset          = rst;
      arr_valid      = v;
      arr_we         = we;
      arr_addr       = a;
      arr_di         = d;
      arr_resp_ready = rr;
      #1;
      ready_m = (init_left == 0) && (exp_q.size() == 0 || rr);
      if (!rst) chk("ready", {31'd0, arr_ready}, {31'd0, ready_m});
      acc = v && ready_m && !rst;
      if (rst) begin
         exp_q.delete();
         foreach (mem_m[i]) mem_m[i] = 8'd0;
         init_left = 256;
      end else begin
         if (init_left > 0) init_left--;
         if (exp_q.size() != 0 && rr) void'(exp_q.pop_front());
         if (acc) begin
            exp_q.push_back(mem_m[a]);
            if (we) mem_m[a] = d;
         end
      end
      @(negedge clk);
      chk("resp_valid", {31'd0, arr_resp_valid}, {31'd0, exp_q.size() != 0});
      if (exp_q.size() != 0) chk("resp_data", {24'd0, arr_do}, {24'd0, exp_q[0]});
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 8'd0, 8'd0, 1);
   endtask

   initial begin
      int n;
      logic [7:0] old;
      foreach (mem_m[i]) mem_m[i] = 8'd0;
      reset = 1'b1; arr_valid = 0; arr_we = 0; arr_addr = 0; arr_di = 0; arr_resp_ready = 1;
      @(negedge clk);
      step(1, 0, 0, 8'd0, 8'd0, 1);
      step(1, 0, 0, 8'd0, 8'd0, 1);
      chk("rst_ready", {31'd0, arr_ready}, 32'd0);
      chk("rst_do", {24'd0, arr_do}, 32'd0);

      n = 0;
      while (!arr_ready && n < 1000) begin
         step(0, 0, 0, 8'd0, 8'd0, 1);
         n++;
      end
      chk("init_cycles", n, 256);

      step(0, 1, 0, 8'd3, 8'd0, 1);
      chk("rd3_clear", {24'd0, arr_do}, 32'd0);
      idle(1);

      step(0, 1, 1, 8'd3, 8'd42, 1);
      chk("wr3_old", {24'd0, arr_do}, 32'd0);
      idle(1);
      step(0, 1, 0, 8'd3, 8'd0, 1);
      chk("rd3_new", {24'd0, arr_do}, 32'd42);
      idle(1);

      step(0, 1, 1, 8'd5, 8'd7, 1);
      chk("bb0", {24'd0, arr_do}, 32'd0);
      step(0, 1, 0, 8'd5, 8'd0, 1);
      chk("bb1", {24'd0, arr_do}, 32'd7);
      step(0, 1, 1, 8'd5, 8'd9, 1);
      chk("bb2", {24'd0, arr_do}, 32'd7);
      step(0, 1, 0, 8'd5, 8'd0, 1);
      chk("bb3", {24'd0, arr_do}, 32'd9);
      idle(1);

      step(0, 1, 0, 8'd3, 8'd0, 1);
      for (int i = 0; i < 4; i++) begin
         step(0, 1, 0, 8'd5, 8'd0, 0);
         chk("hold_ready", {31'd0, arr_ready}, 32'd0);
         chk("hold_do", {24'd0, arr_do}, 32'd42);
      end
      step(0, 1, 0, 8'd5, 8'd0, 1);
      chk("release_do", {24'd0, arr_do}, 32'd9);
      idle(1);

      step(0, 1, 1, 8'd3, 8'd42, 0);
      chk("pend_valid", {31'd0, arr_resp_valid}, 32'd1);
      step(1, 0, 0, 8'd0, 8'd0, 0);
      chk("rst_drop", {31'd0, arr_resp_valid}, 32'd0);
      idle(256);
      step(0, 1, 0, 8'd3, 8'd0, 1);
      chk("rd3_after_rst", {24'd0, arr_do}, 32'd0);
      idle(1);

      // Add-at-address client: read 3, write back old+42, read it again.
      step(0, 1, 0, 8'd3, 8'd0, 1);
      old = arr_do;
      step(0, 1, 1, 8'd3, old + 8'd42, 1);
      step(0, 1, 0, 8'd3, 8'd0, 1);
      chk("add_at", {24'd0, arr_do}, 32'd42);
      idle(1);

      for (int i = 0; i < 500; i++) begin
         step(0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
              8'($urandom_range(0, 7)), 8'($urandom), $urandom_range(0, 3) != 0);
      end
      idle(2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
